// File: rtl/frame_dump_if.sv
// SRAM read port and outbound byte stream used by the framebuffer dumper.
// The master side is the dumper; the slave side is the SRAM mux and byte sink.
interface frame_dump_if;
  logic [17:0] address;
  logic        ram_read;
  logic [15:0] data_read;
  logic        ram_ready;
  logic        clk_en;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output address, ram_read, out_data, out_valid,
    input  data_read, ram_ready, clk_en, out_ready
  );

  modport slave (
    input  address, ram_read, out_data, out_valid,
    output data_read, ram_ready, clk_en, out_ready
  );
endinterface

// File: rtl/frame_dump.sv
// Streams a 1 bpp framebuffer out of SRAM as bytes (high byte first) during SRAM grant windows.
// Optional macro FRAME_DUMP_CHECKSUM_EN appends a 16-bit word sum (high byte first) after the frame.
//
// state   | meaning
// IDLE    | waiting for start
// REQ     | holding the word address, waiting for the SRAM grant
// WAIT    | read issued, waiting for ram_ready
// SEND_HI | presenting word[15:8]
// SEND_LO | presenting word[7:0]
// SUM_HI  | presenting sum[15:8] (checksum build only)
// SUM_LO  | presenting sum[7:0] (checksum build only)
// FINISH  | done pulse, back to IDLE
module frame_dump #(
  parameter logic [17:0] BASE_ADDR   = 18'd0,
  parameter int          FRAME_WORDS = 19200
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  frame_dump_if.master bus,
  output logic         busy,
  output logic         done
);

  localparam int CNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    SEND_HI,
    SEND_LO,
`ifdef FRAME_DUMP_CHECKSUM_EN
    SUM_HI,
    SUM_LO,
`endif
    FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] word_cnt_q;
  logic [15:0]      word_q;
  logic             ram_read_q, ram_read_d;
  logic             load, capture, advance;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ram_read_d = 1'b0;
    load       = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    case (state_q)
      IDLE, FINISH: begin
        if (start) begin
          load    = 1'b1;
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.clk_en) begin
          ram_read_d = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        // Returned data is taken even if the grant drops in the same cycle.
        if (bus.ram_ready) begin
          capture = 1'b1;
          state_d = SEND_HI;
        end else if (!bus.clk_en) begin
          state_d = REQ;
        end else begin
          ram_read_d = 1'b1;
        end
      end
      SEND_HI: begin
        if (bus.out_ready) state_d = SEND_LO;
      end
      SEND_LO: begin
        if (bus.out_ready) begin
          if (word_cnt_q == LAST_CNT) begin
`ifdef FRAME_DUMP_CHECKSUM_EN
            state_d = SUM_HI;
`else
            state_d = FINISH;
`endif
          end else begin
            advance = 1'b1;
            state_d = REQ;
          end
        end
      end
`ifdef FRAME_DUMP_CHECKSUM_EN
      SUM_HI: begin
        if (bus.out_ready) state_d = SUM_LO;
      end
      SUM_LO: begin
        if (bus.out_ready) state_d = FINISH;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt_q <= '0;
      word_q     <= '0;
      ram_read_q <= 1'b0;
    end else begin
      ram_read_q <= ram_read_d;
      if (load)         word_cnt_q <= '0;
      else if (advance) word_cnt_q <= word_cnt_q + CNT_W'(1);
      if (capture)      word_q     <= bus.data_read;
    end
  end

`ifdef FRAME_DUMP_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk) begin
    if (reset)        sum_q <= '0;
    else if (load)    sum_q <= '0;
    else if (capture) sum_q <= sum_q + bus.data_read;
  end
`endif

  assign bus.address  = BASE_ADDR + 18'(word_cnt_q);
  assign bus.ram_read = ram_read_q;

  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_data  = 8'h00;
    case (state_q)
      SEND_HI: begin
        bus.out_valid = 1'b1;
        bus.out_data  = word_q[15:8];
      end
      SEND_LO: begin
        bus.out_valid = 1'b1;
        bus.out_data  = word_q[7:0];
      end
`ifdef FRAME_DUMP_CHECKSUM_EN
      SUM_HI: begin
        bus.out_valid = 1'b1;
        bus.out_data  = sum_q[15:8];
      end
      SUM_LO: begin
        bus.out_valid = 1'b1;
        bus.out_data  = sum_q[7:0];
      end
`endif
      default: begin
        bus.out_valid = 1'b0;
        bus.out_data  = 8'h00;
      end
    endcase
  end

  assign busy = (state_q != IDLE) && (state_q != FINISH);
  assign done = (state_q == FINISH);

endmodule
